// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: data width, M-extension funct codes, FSM states.
package rv_pipe_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        FN_MUL    = 3'b000,
        FN_MULH   = 3'b001,
        FN_MULHSU = 3'b010,
        FN_MULHU  = 3'b011,
        FN_DIV    = 3'b100,
        FN_DIVU   = 3'b101,
        FN_REM    = 3'b110,
        FN_REMU   = 3'b111
    } funct_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_e;

    // Divide-class operations all have funct[2] set.
    function automatic logic funct_is_div(funct_e f);
        return f[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide request/response bundle.
interface ex_muldiv_if;
    import rv_pipe_pkg::*;

    logic            flush;
    logic            start;
    logic [2:0]      funct;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output flush, start, funct, op1, op2,
        input  busy, done, result
    );

    modport slave (
        input  flush, start, funct, op1, op2,
        output busy, done, result
    );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring
// shift-subtract steps on magnitudes, then sign correction in FIN.
module ex_muldiv
    import rv_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);

    state_e            state;
    state_e            state_nxt;
    funct_e            funct_in;
    funct_e            op_q;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] work;
    logic [2*XLEN-1:0] work_nxt;
    logic [4:0]        cnt;
    logic              neg_main;
    logic              neg_rem;
    logic [XLEN-1:0]   result_q;
    logic              done_q;

    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;
    logic              neg_main_in;
    logic              neg_rem_in;
    logic              accept;
    logic              run_step;
    logic              finish;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fin_result;

    assign funct_in = funct_e'(bus.funct);
    assign accept   = (state == IDLE) && bus.start && !bus.flush;
    assign run_step = (state == RUN) && !bus.flush;
    assign finish   = (state == FIN) && !bus.flush;

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // Operand magnitudes and the sign corrections the result will need.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (funct_in)
            FN_MULH, FN_DIV, FN_REM: begin
                sign_a = bus.op1[XLEN-1];
                sign_b = bus.op2[XLEN-1];
            end
            FN_MULHSU: sign_a = bus.op1[XLEN-1];
            default: ;
        endcase
        mag_a_in = sign_a ? -bus.op1 : bus.op1;
        mag_b_in = sign_b ? -bus.op2 : bus.op2;
        // A zero divisor keeps the all-ones quotient and op1 remainder
        // unnegated; for multiply a zero op2 makes the flag irrelevant.
        neg_main_in = (sign_a ^ sign_b) && (bus.op2 != '0);
        neg_rem_in  = sign_a;
    end

    // One iteration of the shared datapath.
    always_comb begin
        div_ge   = (work[2*XLEN-1:XLEN-1] >= {1'b0, mag_b});
        div_diff = work[2*XLEN-2:XLEN-1] - mag_b;
        mul_sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, mag_b} : '0);
        if (funct_is_div(op_q)) begin
            work_nxt = div_ge ? {div_diff, work[XLEN-2:0], 1'b1}
                              : {work[2*XLEN-2:0], 1'b0};
        end else begin
            work_nxt = {mul_sum, work[XLEN-1:1]};
        end
    end

    // Sign correction and result-half selection.
    always_comb begin
        fin_result = '0;
        prod       = neg_main ? -work : work;
        case (op_q)
            FN_MUL:                       fin_result = prod[XLEN-1:0];
            FN_MULH, FN_MULHSU, FN_MULHU: fin_result = prod[2*XLEN-1:XLEN];
            FN_DIV, FN_DIVU:              fin_result = neg_main ? -work[XLEN-1:0] : work[XLEN-1:0];
            default:                      fin_result = neg_rem ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
        end
    end

    // Operand capture, iteration, and result/done update.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= FN_MUL;
            mag_b    <= '0;
            work     <= '0;
            cnt      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q     <= funct_in;
                mag_b    <= mag_b_in;
                work     <= {{XLEN{1'b0}}, mag_a_in};
                cnt      <= '0;
                neg_main <= neg_main_in;
                neg_rem  <= neg_rem_in;
            end else if (run_step) begin
                work <= work_nxt;
                cnt  <= cnt + 5'd1;
            end else if (finish) begin
                result_q <= fin_result;
                done_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: reference model plus per-cycle compare, directed
// literal cases, then a randomized start/flush/rst soak.
module tb_ex_muldiv;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: cycles left until done (0 = idle).
    int          m_left    = 0;
    logic [31:0] m_pending = '0;
    logic [31:0] m_result  = '0;
    logic        m_done    = 1'b0;
    bit          m_valid   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int              ia;
        int              ib;
        longint          sa;
        longint          sb;
        longint          ub;
        longint          p;
        longint unsigned ua_u;
        longint unsigned ub_u;
        longint unsigned pu;
        ia   = a;
        ib   = b;
        sa   = ia;
        sb   = ib;
        ub   = longint'({32'd0, b});
        ua_u = {32'd0, a};
        ub_u = {32'd0, b};
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin pu = ua_u * ub_u; return pu[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                pu = ua_u / ub_u;
                return pu[31:0];
            end
            3'b110: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                pu = ua_u % ub_u;
                return pu[31:0];
            end
        endcase
    endfunction

    // Model advances on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_valid  = 1'b1;
            m_left   = 0;
            m_result = '0;
        end else if (bus.flush) begin
            m_left = 0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_left    = 33;
                m_pending = ref_op(bus.funct, bus.op1, bus.op2);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_done   = 1'b1;
                m_result = m_pending;
            end
        end
    end

    // Every cycle after the first reset: outputs must match the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_busy", bus.busy, (m_left != 0));
            check("cyc_done", bus.done, m_done);
            check("cyc_result", bus.result, m_result);
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return {28'd0, v[3:0]};
            5: return {28'hFFF_FFFF, v[3:0]};
            default: return v;
        endcase
    endfunction

    // Called at a falling edge with the unit idle; returns at the falling
    // edge where done is seen, so a following call runs back-to-back.
    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit);
        int cyc;
        int busy_n;
        bus.start = 1'b1;
        bus.funct = f;
        bus.op1   = a;
        bus.op2   = b;
        @(negedge clk);
        bus.start = 1'b0;
        cyc    = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.busy === 1'b1) busy_n++;
            // Garbage on the request lines while busy must be ignored.
            bus.start = 1'($urandom_range(0, 1));
            bus.funct = 3'($urandom_range(0, 7));
            bus.op1   = $urandom;
            bus.op2   = $urandom;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({name, "_result"}, bus.result, lit);
        check({name, "_latency"}, cyc, 34);
        check({name, "_busy_cycles"}, busy_n, 33);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.funct = '0;
        bus.op1   = '0;
        bus.op2   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op("mul_7x6", 3'b000, 32'd7, 32'd6, 32'h0000_002A);
        @(negedge clk);
        do_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_op("divu_100_0", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF);
        do_op("remu_100_0", 3'b111, 32'd100, 32'd0, 32'd100);
        do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op("div_m9_0", 3'b100, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF);
        do_op("rem_m9_0", 3'b110, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7);
        do_op("mul_7x6_b", 3'b000, 32'd7, 32'd6, 32'h0000_002A);

        // Flush ten cycles into a divide.
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct = 3'b100;
        bus.op1   = 32'd1000;
        bus.op2   = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_done", bus.done, 0);
        check("flush_result", bus.result, 32'h0000_002A);
        do_op("divu_after_flush", 3'b101, 32'd1000, 32'd7, 32'd142);

        // Flush wins over a simultaneous start in IDLE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", bus.busy, 0);

        // Reset mid-RUN, then a back-to-back pair.
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct = 3'b000;
        bus.op1   = 32'd3;
        bus.op2   = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_busy", bus.busy, 0);
        check("rst_run_done", bus.done, 0);
        check("rst_run_result", bus.result, 0);
        do_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        do_op("rem_100_m7", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2);

        // Randomized soak; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 99) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            bus.funct = 3'($urandom_range(0, 7));
            bus.op1   = pick();
            bus.op2   = pick();
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.flush = 1'b0;
        rst       = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL expose clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL expose rst, input, 1, reset, synchronous, active-high; clock clk.
REQ-003 SHALL expose flush, input, 1, synchronous pipeline flush from the hazard unit; aborts any operation in progress.
REQ-004 SHALL expose start, input, 1, request from the ID/EX register; sampled only in IDLE.
REQ-005 SHALL expose funct, input, 3, operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL expose op1, input, 32, rs1 operand from the ID/EX register.
REQ-007 SHALL expose op2, input, 32, rs2 operand from the ID/EX register.
REQ-008 SHALL expose busy, output, 1, stall request; the ID/EX register and upstream stages hold while it is high.
REQ-009 SHALL expose done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL expose result, output, 32, RV32M result; held stable until the next done.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and FIN; the reset state is IDLE.
REQ-012 In IDLE with start=1 and flush=0, SHALL latch op1, op2 and funct, form operand magnitudes and result-sign flags per funct, clear the 5-bit iteration counter and go to RUN.
REQ-013 In RUN, SHALL perform one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide, over a 64-bit working register.
REQ-014 SHALL leave RUN for FIN after exactly 32 RUN cycles, when the counter wraps from 31.
REQ-015 In FIN, SHALL apply sign correction, select the result half (low 32 for MUL, high 32 for MULH*, quotient or remainder for DIV/REM), update result, assert done, and go to IDLE.
REQ-016 Latency SHALL be fixed: start sampled at edge N gives done=1 in the cycle after edge N+33, for every funct and every operand value.
REQ-017 busy SHALL be high exactly in RUN and FIN, and low in IDLE.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 MULH SHALL treat both operands as signed; MULHSU SHALL treat op1 as signed and op2 as unsigned; MULHU SHALL treat both as unsigned.
REQ-020 DIV/REM SHALL truncate toward zero, and the remainder SHALL take the sign of op1.
REQ-021 For op2=0, DIV/DIVU SHALL return 0xFFFFFFFF and REM/REMU SHALL return op1, with the same fixed latency.
REQ-022 For DIV with op1=0x80000000 and op2=0xFFFFFFFF, SHALL return 0x80000000; the matching REM SHALL return 0.
REQ-023 flush=1 in any state SHALL force IDLE at the next edge, with no done pulse; result SHALL keep its previous value.
REQ-024 When flush=1 and start=1 occur together in IDLE, flush SHALL win and the start SHALL be dropped.
REQ-025 A start arriving in the IDLE cycle right after FIN SHALL be accepted, so back-to-back operations run with no extra bubble.

Reset
REQ-026 rst=1 SHALL set state to IDLE, busy=0, done=0, result=0, counter=0 and clear the working registers.
REQ-027 rst SHALL take priority over flush and start, and SHALL abort a RUN or FIN mid-operation with no done pulse.

Structure
REQ-028 The shared package rv_pipe_pkg SHALL hold the funct encodings, the state enumeration and XLEN=32.
REQ-029 The block SHALL be a single module with no sub-module; the datapath is one iterative unit shared by multiply and divide.

Verification
REQ-030 MUL 7 x 6 -> done 34 cycles after start, result=0x0000002A; busy high for 33 cycles.
REQ-031 MULH 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000000; MULHU on the same operands -> result=0xFFFFFFFE.
REQ-032 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 % 0 -> 100.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM on the same operands -> 0, both with full latency.
REQ-034 flush asserted 10 cycles into a DIV -> next cycle busy=0, no done pulse, result unchanged; a new start is then accepted.
REQ-035 rst asserted during RUN, and start asserted on the cycle after FIN -> reset values within one cycle; the back-to-back op gives done 34 cycles after its start.
